// File: rtl/multiplicador_secuencial_param.sv
// Sequential shift-add multiplier for WIDTH-bit operands with a signed/unsigned mode.
// Works on operand magnitudes, stops once the remaining multiplier bits are zero, and fixes the sign at the end.
module multiplicador_secuencial_param #(
  parameter int WIDTH = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Multiplicando,
  input  logic [WIDTH-1:0]   Multiplicador,
  output logic [2*WIDTH-1:0] Producto,
  output logic               Ready,
  output logic               Done
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   q_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] producto_q;
  logic               done_q;

  logic [WIDTH-1:0]   mcandMag;
  logic [WIDTH-1:0]   mplierMag;
  logic [2*WIDTH-1:0] p_d;
  logic [2*WIDTH-1:0] m_d;
  logic [WIDTH-1:0]   q_d;

  // The most-negative operand negates to itself, which reads correctly as an unsigned magnitude.
  assign mcandMag  = (Signed && Multiplicando[WIDTH-1]) ? -Multiplicando : Multiplicando;
  assign mplierMag = (Signed && Multiplicador[WIDTH-1]) ? -Multiplicador : Multiplicador;

  assign p_d = q_q[0] ? (p_q + m_q) : p_q;
  assign m_d = m_q << 1;
  assign q_d = q_q >> 1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      p_q        <= '0;
      q_q        <= '0;
      neg_q      <= 1'b0;
      producto_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            m_q     <= {{WIDTH{1'b0}}, mcandMag};
            q_q     <= mplierMag;
            neg_q   <= Signed & (Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1]);
            p_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          p_q <= p_d;
          m_q <= m_d;
          q_q <= q_d;
          // Leaving as soon as no set multiplier bits remain gives the early termination.
          if (q_d == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          producto_q <= neg_q ? -p_q : p_q;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Producto = producto_q;
  assign Done     = done_q;
  assign Ready    = (state_q == IDLE);

endmodule
